// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - mode/time-set controller and 1 Hz timebase for the clock datapath
// Optional macro AUTO_REPEAT_EN adds held-button auto-repeat of the set increment.
module clock_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int RPT_DLY  = 25_000_000,
    parameter int RPT_DIV  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_en,
    output logic       sec_clr,
    output logic       min_en,
    output logic       hour_en,
    output logic [1:0] mode,
    output logic       blink
);
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_BAD      = 2'd3
    } mode_e;

    localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(TICK_DIV / 2 - 1);

    generate
        if (TICK_DIV < 4 || (TICK_DIV % 2) != 0 || RPT_DLY < 1 || RPT_DIV < 1) begin : g_bad_cfg
            $error("clock_ctrl: invalid parameters");
        end
    endgenerate

    mode_e         mode_q, mode_d;
    logic [DW-1:0] div_q, div_d;
    logic          blink_q, blink_d;
    logic          btn_mode_q, btn_set_q;
    logic          press_mode, press_set;
    logic          tick, half, run, run_next, rpt, inc;

    // History regs reset high so a button held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_RUN;
            div_q      <= '0;
            blink_q    <= 1'b0;
            btn_mode_q <= 1'b1;
            btn_set_q  <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            div_q      <= div_d;
            blink_q    <= blink_d;
            btn_mode_q <= btn_mode;
            btn_set_q  <= btn_set;
        end
    end

    assign press_mode = btn_mode & ~btn_mode_q;
    assign press_set  = btn_set & ~btn_set_q;
    assign tick       = (div_q == DIV_LAST);
    assign half       = (div_q == DIV_HALF);
    assign run        = (mode_q != MODE_SET_HOUR) && (mode_q != MODE_SET_MIN);
    assign inc        = (press_set | rpt) & ~press_mode;

    always_comb begin
        mode_d = MODE_RUN;
        case (mode_q)
            MODE_RUN:      mode_d = press_mode ? MODE_SET_HOUR : MODE_RUN;
            MODE_SET_HOUR: mode_d = press_mode ? MODE_SET_MIN  : MODE_SET_HOUR;
            MODE_SET_MIN:  mode_d = press_mode ? MODE_RUN      : MODE_SET_MIN;
            default:       mode_d = MODE_RUN;
        endcase
    end

    assign run_next = (mode_d == MODE_RUN);

    // Leaving SET_MIN restarts the timebase so the first second after setting is full length.
    always_comb begin
        div_d = div_q + DW'(1);
        if ((mode_q == MODE_SET_MIN && press_mode) || tick) begin
            div_d = '0;
        end
    end

    always_comb begin
        blink_d = blink_q;
        if (run_next) begin
            blink_d = 1'b0;
        end else if (!run && (tick || half)) begin
            blink_d = ~blink_q;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DLY > RPT_DIV) ? RPT_DLY : RPT_DIV;
    localparam int HW      = $clog2(RPT_MAX + 1);

    logic [HW-1:0] hold_q, hold_d, hold_target;
    logic          rpt_phase_q, rpt_phase_d;
    logic          hold_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            rpt_phase_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end

    // hold_q == 0 means idle; it only arms on a genuine press inside a SET mode.
    always_comb begin
        hold_active = btn_set & ~run & ~press_mode;
        hold_target = rpt_phase_q ? HW'(RPT_DIV) : HW'(RPT_DLY);
        hold_d      = hold_q;
        rpt_phase_d = rpt_phase_q;
        rpt         = 1'b0;
        if (!hold_active) begin
            hold_d      = '0;
            rpt_phase_d = 1'b0;
        end else if (press_set) begin
            hold_d      = HW'(1);
            rpt_phase_d = 1'b0;
        end else if (hold_q != '0) begin
            if (hold_q == hold_target) begin
                rpt         = 1'b1;
                hold_d      = HW'(1);
                rpt_phase_d = 1'b1;
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif

    assign sec_en  = tick & run;
    assign sec_clr = ~run;
    assign min_en  = run ? sec_carry : ((mode_q == MODE_SET_MIN) & inc);
    assign hour_en = run ? min_carry : ((mode_q == MODE_SET_HOUR) & inc);
    assign mode    = mode_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - scoreboard bench for clock_ctrl with a cycle-count reference model
module tb_clock_ctrl;
    localparam int TD = 10;
    localparam int RD = 8;
    localparam int RV = 3;

    logic       clk = 1'b0;
    logic       rst, btn_mode, btn_set, sec_carry, min_carry;
    logic       sec_en, sec_clr, min_en, hour_en, blink;
    logic [1:0] mode;

    clock_ctrl #(.TICK_DIV(TD), .RPT_DLY(RD), .RPT_DIV(RV)) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_set(btn_set),
        .sec_carry(sec_carry), .min_carry(min_carry),
        .sec_en(sec_en), .sec_clr(sec_clr), .min_en(min_en), .hour_en(hour_en),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sec_en;
        logic       sec_clr;
        logic       min_en;
        logic       hour_en;
        logic [1:0] mode;
        logic       blink;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t o;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    int m_mode, m_t0, m_hp;
    bit m_blink, m_pm, m_ps, m_hold;

    int sec_cnt_obs = 0;
    int min_cnt_obs = 0;
    int last_sec_cyc = -1;

    always @(negedge clk) begin
        exp_t  e;
        outs_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {sec_en, sec_clr, min_en, hour_en, mode, blink};
            total++;
            if (a !== e.o) begin
                bad++;
                $display("FAIL outputs cyc=%0d got sec_en=%b sec_clr=%b min_en=%b hour_en=%b mode=%0d blink=%b exp sec_en=%b sec_clr=%b min_en=%b hour_en=%b mode=%0d blink=%b",
                         e.cyc, a.sec_en, a.sec_clr, a.min_en, a.hour_en, a.mode, a.blink,
                         e.o.sec_en, e.o.sec_clr, e.o.min_en, e.o.hour_en, e.o.mode, e.o.blink);
            end
            if (sec_en === 1'b1) begin
                sec_cnt_obs++;
                last_sec_cyc = e.cyc;
            end
            if (min_en === 1'b1) min_cnt_obs++;
        end
    end

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Reference: timebase phase is cycles elapsed since the last restart, modulo TD.
    task automatic model(input bit r, input bit bm, input bit bs, input bit sc, input bit mc);
        exp_t e;
        int   ph, nxt, k;
        bit   tick, half, pmode, pset, run, rep, inc;
        if (r) begin
            m_mode = 0; m_t0 = cyc + 1; m_blink = 0;
            m_pm = 1; m_ps = 1; m_hold = 0; m_hp = 0;
            return;
        end
        ph    = (cyc - m_t0) % TD;
        tick  = (ph == TD - 1);
        half  = (ph == TD / 2 - 1);
        pmode = bm && !m_pm;
        pset  = bs && !m_ps;
        run   = (m_mode == 0);
        rep   = 0;
        k     = cyc - m_hp;
`ifdef AUTO_REPEAT_EN
        if (m_hold && bs && !run && !pmode && !pset)
            rep = (k == RD) || (k > RD && ((k - RD) % RV) == 0);
`endif
        inc = (pset || rep) && !pmode;
        e.cyc       = cyc;
        e.o.sec_en  = tick && run;
        e.o.sec_clr = !run;
        e.o.min_en  = run ? sc : (m_mode == 2 && inc);
        e.o.hour_en = run ? mc : (m_mode == 1 && inc);
        e.o.mode    = 2'(m_mode);
        e.o.blink   = m_blink;
        sb.push_back(e);
        nxt = pmode ? (m_mode + 1) % 3 : m_mode;
        if (nxt == 0) m_blink = 0;
        else if (!run && (tick || half)) m_blink = !m_blink;
        if (pmode && m_mode == 2) m_t0 = cyc + 1;
        if (!bs || run || pmode) m_hold = 0;
        else if (pset) begin
            m_hold = 1;
            m_hp   = cyc;
        end
        m_mode = nxt; m_pm = bm; m_ps = bs;
    endtask

    task automatic step(input bit r, input bit bm, input bit bs, input bit sc, input bit mc);
        @(posedge clk);
        #1;
        rst = r; btn_mode = bm; btn_set = bs; sec_carry = sc; min_carry = mc;
        model(r, bm, bs, sc, mc);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic press_mode_btn();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int p;
        bit bm, bs;
        int bm_left, bs_left;
        rst = 1'b1; btn_mode = 1'b0; btn_set = 1'b0; sec_carry = 1'b0; min_carry = 1'b0;

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        settle();
        sec_cnt_obs = 0;
        idle(35);
        settle();
        check_int("run_sec_en_count", sec_cnt_obs, 3);

        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        idle(2);

        press_mode_btn();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        idle(12);

        press_mode_btn();
        idle(3);
        p = cyc;
        step(0, 1, 0, 0, 0);
        last_sec_cyc = -1;
        idle(11);
        settle();
        check_int("run_entry_sec_delay", last_sec_cyc - p, 10);

        press_mode_btn();
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        settle();
        check_int("mode_set_and_mode", int'(mode), 2);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        settle();
        check_int("held_mode_after_rst", int'(mode), 0);
        step(0, 0, 0, 0, 0);
        press_mode_btn();
        press_mode_btn();
        settle();
        check_int("reached_set_min", int'(mode), 2);

        min_cnt_obs = 0;
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
        settle();
`ifdef AUTO_REPEAT_EN
        check_int("set_min_repeat_pulses", min_cnt_obs, 5);
`else
        check_int("set_min_repeat_pulses", min_cnt_obs, 1);
`endif
        idle(2);
        press_mode_btn();

        bm = 0; bs = 0; bm_left = 5; bs_left = 5;
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 399) == 0);
            if (--bm_left <= 0) begin
                bm = ~bm;
                bm_left = bm ? $urandom_range(1, 4) : $urandom_range(3, 25);
            end
            if (--bs_left <= 0) begin
                bs = ~bs;
                bs_left = $urandom_range(1, 30);
            end
            step(r, bm, bs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(3);
        settle();
        check_int("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
